// File: rtl/convpress_node_ctrl_if.sv
// Handshake/config bundle between a convpress node client and its sequencer.
// Optional CONVPRESS_CTRL_STALL_EN adds the eDRAM back-pressure input i_edram_ready.
interface convpress_node_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 4
);
    logic                 i_start;
    logic [ADDR_SIZE-1:0] i_cfg_num_in;
    logic [ADDR_SIZE-1:0] i_cfg_num_out;
`ifdef CONVPRESS_CTRL_STALL_EN
    logic                 i_edram_ready;
`endif
    logic [ADDR_SIZE-1:0] o_nbin_addr;
    logic [ADDR_SIZE-1:0] o_nbout_addr;
    logic                 o_load_coef;
    logic                 o_acc_en;
    logic                 o_out_valid;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_start, i_cfg_num_in, i_cfg_num_out,
`ifdef CONVPRESS_CTRL_STALL_EN
        output i_edram_ready,
`endif
        input  o_nbin_addr, o_nbout_addr, o_load_coef, o_acc_en,
        input  o_out_valid, o_busy, o_done
    );

    modport slave (
        input  i_start, i_cfg_num_in, i_cfg_num_out,
`ifdef CONVPRESS_CTRL_STALL_EN
        input  i_edram_ready,
`endif
        output o_nbin_addr, o_nbout_addr, o_load_coef, o_acc_en,
        output o_out_valid, o_busy, o_done
    );
endinterface

// File: rtl/convpress_node_ctrl.sv
// Job sequencer for one convpress node: coefficient load, NBin/NBout address stepping, pipeline drain.
// Define CONVPRESS_CTRL_STALL_EN to enable eDRAM back-pressure (i_edram_ready) in ACC/DRAIN.
module convpress_node_ctrl #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned PIPE_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    convpress_node_ctrl_if.slave bus
);
    localparam int unsigned LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COEF  = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   num_in_q, num_in_d;
    logic [ADDR_SIZE-1:0]   num_out_q, num_out_d;
    logic [ADDR_SIZE-1:0]   in_cnt_q, in_cnt_d;
    logic [ADDR_SIZE-1:0]   out_cnt_q, out_cnt_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [PIPE_LAT-1:0]    sr_q, sr_d;
    logic                   load_coef_q, load_coef_d;
    logic                   acc_en_q, acc_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   ready_c;
    logic                   hold_c;
    logic                   last_in_c;
    logic                   last_out_c;
    logic                   tile_end_c;

`ifdef CONVPRESS_CTRL_STALL_EN
    assign ready_c = bus.i_edram_ready;
`else
    assign ready_c = 1'b1;
`endif

    // Back-pressure only freezes the accumulate and drain phases; COEF always proceeds.
    assign hold_c     = !ready_c && ((state_q == S_ACC) || (state_q == S_DRAIN));
    assign last_in_c  = (in_cnt_q  == (num_in_q  - ADDR_SIZE'(1)));
    assign last_out_c = (out_cnt_q == (num_out_q - ADDR_SIZE'(1)));
    assign tile_end_c = (state_q == S_ACC) && last_in_c && !hold_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_in_q    <= '0;
            num_out_q   <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            sr_q        <= '0;
            load_coef_q <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_in_q    <= num_in_d;
            num_out_q   <= num_out_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            sr_q        <= sr_d;
            load_coef_q <= load_coef_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d   = state_q;
        num_in_d  = num_in_q;
        num_out_d = num_out_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        lat_cnt_d = lat_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    num_in_d  = bus.i_cfg_num_in;
                    num_out_d = bus.i_cfg_num_out;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    lat_cnt_d = '0;
                    if ((bus.i_cfg_num_in == '0) || (bus.i_cfg_num_out == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COEF;
                    end
                end
            end
            S_COEF: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                if (!hold_c) begin
                    if (last_in_c) begin
                        // Last accumulate of the job leaves the addresses on their final values.
                        if (last_out_c) begin
                            state_d   = S_DRAIN;
                            lat_cnt_d = '0;
                        end else begin
                            in_cnt_d  = '0;
                            out_cnt_d = out_cnt_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        in_cnt_d = in_cnt_q + ADDR_SIZE'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!hold_c) begin
                    if (lat_cnt_q == LAT_W'(PIPE_LAT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sr_d        = hold_c ? sr_q : PIPE_LAT'({sr_q, tile_end_c});
        load_coef_d = (state_d == S_COEF);
        acc_en_d    = (state_d == S_ACC);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    assign bus.o_nbin_addr  = in_cnt_q;
    assign bus.o_nbout_addr = out_cnt_q;
    assign bus.o_load_coef  = load_coef_q;
    assign bus.o_acc_en     = acc_en_q & ready_c;
    assign bus.o_out_valid  = sr_q[PIPE_LAT-1] & ready_c;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;

endmodule
